hazard_tracker: RTL
===================

# hazard_tracker

Parametrised pipeline hazard tracker for the pipelined MIPS core. It merges load-use stall detection, operand forwarding selection and branch-redirect flushing into one stateful block. The block keeps a shadow shift register of in-flight register writers, one slot per stage after ID, and sits beside the ID stage. It drives the PC, IF/ID and ID/EX control enables and the per-operand forwarding selects for the whole pipe.

## Interface
Parameters:
- REG_W, 5, register address width
- DEPTH, 3, tracked stages after ID (slot 1 = EX … slot DEPTH = WB); legal range DEPTH ≥ 2
- LOAD_READY, 2, first slot index at which load data is forwardable; legal range 1..DEPTH
- BR_STAGE, 1, slot index at which branches/jumps resolve; legal range 1..DEPTH

Ports (FW = $clog2(DEPTH+1)):
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_W  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read
- id_wr_en  in  1  ID instruction writes a register
- id_rd  in  REG_W  ID destination register
- id_is_load  in  1  ID instruction is a load
- redirect_i  in  1  taken branch/jump resolved at slot BR_STAGE
- mem_busy_i  in  1  data memory not ready; freeze pipe
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- pipe_en  out  1  enable for ID/EX and all later pipeline registers
- stall  out  1  insert bubble into ID/EX
- if_id_flush  out  1  clear IF/ID
- fwd_a, fwd_b  out  FW  forward source slot for rs/rt; 0 = register file
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
- State: slot[1..DEPTH], each {v, rd, ld}. A slot is valid only for a register writer with rd ≠ 0.
- Match rule for source s: the match is the smallest k with slot[k].v and slot[k].rd == s. A source matches only when s ≠ 0, its use bit is set and id_valid = 1.
- fwd_a/fwd_b = matched k, else 0. Computed combinationally from state. Slot DEPTH is still forwarded because the register file writes at the end of that cycle.
- Load-use hazard (lu): either source's match has ld = 1 and k < LOAD_READY.
- Mode priority per cycle:
  - FREEZE (mem_busy_i): pc_write = if_id_write = pipe_en = 0, stall = 0, if_id_flush = 0. Slots hold. redirect_i is ignored; its source holds it until consumed.
  - REDIRECT (redirect_i): pc_write = 1, if_id_write = 1, if_id_flush = 1, stall = 1 (the ID instruction is squashed), pipe_en = 1. Slots shift; new slot[1] = invalid; slots 2..BR_STAGE are cleared after the shift. The branch itself moves to BR_STAGE+1 and is kept.
  - LOAD-USE (lu): pc_write = if_id_write = 0, stall = 1, pipe_en = 1. Slots shift; new slot[1] = invalid.
  - NORMAL: all enables = 1, stall = 0. Slots shift; slot[1] = {id_valid & id_wr_en & id_rd≠0, id_rd, id_is_load}.
- Shift: slot[k+1] ← slot[k]; slot[DEPTH] retires.
- Redirect together with lu: REDIRECT wins; no load-use stall is counted.

## Timing
- Reset: all slots invalid on the next edge. Counters are 0. With idle inputs the outputs read pc_write = if_id_write = pipe_en = 1, stall = 0, if_id_flush = 0, fwd = 0.
- All outputs are combinational from current state plus inputs; zero-cycle latency.
- A load-use stall lasts LOAD_READY−k cycles for a match at slot k (defaults: 1 cycle). It is extended by any freeze cycles.
- A writer issued at edge t occupies slot[1] from t until t+1, reaches slot[k] after k−1 non-frozen advances and retires after DEPTH advances.
- A reset asserted mid-stall or mid-freeze aborts it; reset has priority over every mode.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each LOAD-USE cycle.
  - flush_cnt increments on each accepted REDIRECT cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

## Test plan
- ALU chain: add r3 issued, then add r4 using r3 on the next cycle. Response: fwd_a = 1 and no stall. One cycle later a consumer of r3 sees fwd_a = 2; after DEPTH advances it sees 0.
- Load-use: lw r5 followed immediately by a user of r5. Response: exactly one cycle with stall = 1, pc_write = 0, then fwd = 2 (defaults); stall_cnt = 1.
- Freeze: mem_busy_i = 1 for 3 cycles during a pending load-use. Response: slots unchanged, fwd stable, pipe_en = 0; the stall resolves one cycle after busy drops.
- Redirect with BR_STAGE = 2, DEPTH = 4: writers in slots 1 and 2, redirect_i pulsed. Response: if_id_flush = 1, stall = 1; the former slot 1 entry is cleared, the branch moves to slot 3; flush_cnt = 1.
- Redirect together with load-use: redirect wins, pc_write = 1, stall_cnt unchanged; r0 destinations and r0 sources never stall or forward.
- Reset mid-operation: assert reset with all slots valid. Response: the next cycle has fwd = 0, stall = 0 and counters = 0.

Source files
------------

// File: rtl/hazard_tracker.sv
// hazard_tracker: load-use stall, forwarding select and redirect flush for
// the pipelined MIPS core. A shadow shift register records in-flight register
// writers, one slot per stage after ID (slot 1 = EX ... slot DEPTH = WB).
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; without it stall_cnt and flush_cnt are tied to 0.
module hazard_tracker #(
   parameter int REG_W      = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int BR_STAGE   = 1,
   localparam int FW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_is_load,
   input  logic             redirect_i,
   input  logic             mem_busy_i,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             pipe_en,
   output logic             stall,
   output logic             if_id_flush,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
);

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             ld;
   } slot_t;

   typedef enum logic [1:0] {
      MODE_NORMAL,
      MODE_LOAD_USE,
      MODE_REDIRECT,
      MODE_FREEZE
   } mode_e;

   slot_t [DEPTH:1] slot;
   slot_t [DEPTH:1] slot_nxt;
   mode_e           mode;

   logic            live_a;
   logic            live_b;
   logic [FW-1:0]   k_a;
   logic [FW-1:0]   k_b;
   logic            lu_a;
   logic            lu_b;
   logic            lu;

   assign live_a = id_valid & id_use_rs & (id_rs != '0);
   assign live_b = id_valid & id_use_rt & (id_rt != '0);

   // Youngest matching writer per source; scanning oldest-first lets the
   // younger (lower-index) slot overwrite an older match.
   always_comb begin
      k_a  = '0;
      k_b  = '0;
      lu_a = 1'b0;
      lu_b = 1'b0;
      for (int unsigned k = DEPTH; k >= 1; k--) begin
         if (live_a && slot[k].v && (slot[k].rd == id_rs)) begin
            k_a  = FW'(k);
            lu_a = slot[k].ld && (int'(k) < LOAD_READY);
         end
         if (live_b && slot[k].v && (slot[k].rd == id_rt)) begin
            k_b  = FW'(k);
            lu_b = slot[k].ld && (int'(k) < LOAD_READY);
         end
      end
   end

   assign lu    = lu_a | lu_b;
   assign fwd_a = k_a;
   assign fwd_b = k_b;

   // Per-cycle mode: freeze beats redirect beats load-use beats normal.
   always_comb begin
      mode = MODE_NORMAL;
      if (mem_busy_i)
         mode = MODE_FREEZE;
      else if (redirect_i)
         mode = MODE_REDIRECT;
      else if (lu)
         mode = MODE_LOAD_USE;
   end

   // Pipe control enables decoded from the mode.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      pipe_en     = 1'b1;
      stall       = 1'b0;
      if_id_flush = 1'b0;
      unique case (mode)
         MODE_FREEZE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
         end
         MODE_REDIRECT: begin
            stall       = 1'b1;
            if_id_flush = 1'b1;
         end
         MODE_LOAD_USE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stall       = 1'b1;
         end
         default: ;
      endcase
   end

   // Slot advance: hold on freeze, otherwise shift and insert the ID writer
   // (or a bubble); a redirect also squashes the wrong-path writers younger
   // than the branch, which land in slots 2..BR_STAGE after the shift.
   always_comb begin
      slot_nxt = slot;
      if (mode != MODE_FREEZE) begin
         for (int unsigned k = 2; k <= DEPTH; k++)
            slot_nxt[k] = slot[k-1];
         slot_nxt[1] = '0;
         if (mode == MODE_NORMAL) begin
            slot_nxt[1].v  = id_valid & id_wr_en & (id_rd != '0);
            slot_nxt[1].rd = id_rd;
            slot_nxt[1].ld = id_is_load;
         end
         if (mode == MODE_REDIRECT) begin
            for (int unsigned k = 2; k <= BR_STAGE; k++)
               slot_nxt[k] = '0;
         end
      end
   end

   // Slot register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset)
         slot <= '0;
      else
         slot <= slot_nxt;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Saturating counters of load-use stall cycles and accepted redirects.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if ((mode == MODE_LOAD_USE) && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
         if ((mode == MODE_REDIRECT) && (flush_q != '1))
            flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
